// File: rtl/wrf_payload_fifo.sv
// Payload staging FIFO in front of the WR fabric frame generator: buffers 16-bit words,
// announces a frame once PAYLOAD_WORDS are queued and hands them out first-word-fall-through.
module wrf_payload_fifo #(
    parameter int DEPTH_LOG2    = 9,
    parameter int PAYLOAD_WORDS = 104,
    parameter int DATA_W        = 16
) (
    input  logic                  wr_sys_clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  gen_busy,
    input  logic                  pop,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic                  frame_start,
    output logic                  frame_active,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           drop_cnt,
    output logic                  pop_err,
    output logic [15:0]           frames_sent,
    input  logic                  clr_status
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] FRAME_LVL = LVL_W'(PAYLOAD_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SEND  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [LVL_W-1:0]        pop_cnt_q, pop_cnt_d;
    logic [15:0]             drop_cnt_q, drop_cnt_d;
    logic                    pop_err_q, pop_err_d;
    logic [15:0]             frames_sent_q, frames_sent_d;
    logic                    dout_valid_q, dout_valid_d;

    logic [DATA_W-1:0]       mem [DEPTH];
    logic [DATA_W-1:0]       dout_q;

    logic                    full;
    logic                    wr_ok;
    logic                    pop_ok;

    always_comb begin
        full   = (level_q == FULL_LVL);
        wr_ok  = din_valid && !full;
        pop_ok = pop && (state_q == S_SEND) && dout_valid_q;

        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        pop_cnt_d     = pop_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        pop_err_d     = pop_err_q;
        frames_sent_d = frames_sent_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        level_d = level_q + LVL_W'(wr_ok) - LVL_W'(pop_ok);

        // A word written on this edge is not yet readable, so the head is valid
        // next cycle only if something older than this write remains.
        dout_valid_d = ((level_q - LVL_W'(pop_ok)) != '0);

        if (clr_status) begin
            drop_cnt_d = '0;
        end else if (din_valid && full) begin
            drop_cnt_d = sat_inc16(drop_cnt_q);
        end

        if (clr_status) begin
            pop_err_d = 1'b0;
        end else if (pop && !pop_ok) begin
            pop_err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if ((level_q >= FRAME_LVL) && !gen_busy) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                pop_cnt_d = FRAME_LVL;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (pop_ok) begin
                    pop_cnt_d = pop_cnt_q - 1'b1;
                    if (pop_cnt_q == LVL_W'(1)) begin
                        state_d       = S_WAIT;
                        frames_sent_d = frames_sent_q + 16'd1;
                    end
                end
            end
            S_WAIT: begin
                if (!gen_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wr_sys_clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            pop_cnt_q     <= '0;
            drop_cnt_q    <= '0;
            pop_err_q     <= 1'b0;
            frames_sent_q <= '0;
            dout_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            pop_cnt_q     <= pop_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            pop_err_q     <= pop_err_d;
            frames_sent_q <= frames_sent_d;
            dout_valid_q  <= dout_valid_d;
        end
    end

    // Data path: storage and registered head word, never reset.
    always_ff @(posedge wr_sys_clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= din;
        end
        dout_q <= mem[rd_ptr_d];
    end

    assign din_ready    = !full;
    assign dout_valid   = dout_valid_q;
    assign dout         = dout_valid_q ? dout_q : '0;
    assign frame_start  = (state_q == S_START);
    assign frame_active = (state_q == S_START) || (state_q == S_SEND);
    assign level        = level_q;
    assign drop_cnt     = drop_cnt_q;
    assign pop_err      = pop_err_q;
    assign frames_sent  = frames_sent_q;

endmodule

// File: tb/tb_wrf_payload_fifo.sv
// Directed bench for wrf_payload_fifo: threshold, frame readout, overflow, pop errors,
// pointer wrap with back-to-back frames and mid-frame reset.
module tb_wrf_payload_fifo;

    localparam int PW = 104;

    logic        wr_sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        gen_busy = 1'b0;
    logic        pop = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        frame_start;
    logic        frame_active;
    logic [9:0]  level;
    logic [15:0] drop_cnt;
    logic        pop_err;
    logic [15:0] frames_sent;
    logic        clr_status = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] wseq = '0;
    logic [15:0] rseq = '0;

    wrf_payload_fifo #(.DEPTH_LOG2(9), .PAYLOAD_WORDS(PW)) dut (
        .wr_sys_clk  (wr_sys_clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .gen_busy    (gen_busy),
        .pop         (pop),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_start (frame_start),
        .frame_active(frame_active),
        .level       (level),
        .drop_cnt    (drop_cnt),
        .pop_err     (pop_err),
        .frames_sent (frames_sent),
        .clr_status  (clr_status)
    );

    always #5 wr_sys_clk = ~wr_sys_clk;

    task automatic step();
        @(posedge wr_sys_clk);
        #1;
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            din       = wseq;
            din_valid = 1'b1;
            step();
            wseq = wseq + 16'd1;
        end
        din_valid = 1'b0;
    endtask

    task automatic pop_words(input int n);
        pop = 1'b1;
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (dout_valid !== 1'b1 || dout !== rseq) begin
                n_fail++;
                $display("FAIL pop_data[%0d]: got valid=%b dout=%h, expected valid=1 dout=%h",
                         i, dout_valid, dout, rseq);
            end
            step();
            rseq = rseq + 16'd1;
        end
        pop = 1'b0;
    endtask

    task automatic wait_frame_start();
        bit seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (frame_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL frame_start_timeout: got no pulse in 64 cycles, expected a pulse");
        end
    endtask

    task automatic run_frame();
        wait_frame_start();
        step();
        pop_words(PW);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dout !== 16'h0000 ||
            frame_start !== 1'b0 || frame_active !== 1'b0 || level !== 10'd0 ||
            drop_cnt !== 16'd0 || pop_err !== 1'b0 || frames_sent !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b dv=%b dout=%h fs=%b fa=%b lvl=%0d drop=%0d perr=%b sent=%0d, expected 1 0 0000 0 0 0 0 0 0",
                     din_ready, dout_valid, dout, frame_start, frame_active, level, drop_cnt, pop_err, frames_sent);
        end
        rst  = 1'b0;
        wseq = '0;
        rseq = '0;
    endtask

    task automatic test_threshold();
        int early = 0;
        gen_busy = 1'b0;
        for (int i = 0; i < PW - 1; i++) begin
            din = wseq; din_valid = 1'b1;
            step();
            wseq = wseq + 16'd1;
            if (frame_start !== 1'b0) early++;
        end
        din_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (frame_start !== 1'b0) early++;
        end
        n_checks++;
        if (early != 0 || level !== 10'd103) begin
            n_fail++;
            $display("FAIL below_threshold: got early_pulses=%0d level=%0d, expected 0 and 103", early, level);
        end
        write_words(1);
        n_checks++;
        if (level !== 10'd104 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL threshold_edge: got level=%0d fs=%b, expected 104 and 0", level, frame_start);
        end
        step();
        n_checks++;
        if (frame_start !== 1'b1 || frame_active !== 1'b1 || level !== 10'd104) begin
            n_fail++;
            $display("FAIL frame_start_pulse: got fs=%b fa=%b level=%0d, expected 1 1 104", frame_start, frame_active, level);
        end
        step();
        n_checks++;
        if (frame_start !== 1'b0 || frame_active !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_start_single: got fs=%b fa=%b, expected 0 1", frame_start, frame_active);
        end
    endtask

    task automatic test_send_frame();
        pop_words(PW);
        n_checks++;
        if (frame_active !== 1'b0 || frames_sent !== 16'd1 || level !== 10'd0 ||
            dout_valid !== 1'b0 || pop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_end: got fa=%b sent=%0d level=%0d dv=%b perr=%b, expected 0 1 0 0 0",
                     frame_active, frames_sent, level, dout_valid, pop_err);
        end
        step();
    endtask

    task automatic test_pop_err();
        gen_busy = 1'b1;
        write_words(3);
        step();
        n_checks++;
        if (dout !== 16'd104 || dout_valid !== 1'b1 || level !== 10'd3) begin
            n_fail++;
            $display("FAIL idle_head: got dout=%h dv=%b level=%0d, expected 0068 1 3", dout, dout_valid, level);
        end
        pop = 1'b1;
        step();
        pop = 1'b0;
        n_checks++;
        if (pop_err !== 1'b1 || level !== 10'd3 || dout !== 16'd104) begin
            n_fail++;
            $display("FAIL pop_idle: got perr=%b level=%0d dout=%h, expected 1 3 0068", pop_err, level, dout);
        end
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        n_checks++;
        if (pop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_err_clear: got %b, expected 0", pop_err);
        end
    endtask

    task automatic test_full();
        write_words(509);
        n_checks++;
        if (level !== 10'd512 || din_ready !== 1'b0 || drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL fill: got level=%0d rdy=%b drop=%0d, expected 512 0 0", level, din_ready, drop_cnt);
        end
        write_words(5);
        n_checks++;
        if (level !== 10'd512 || din_ready !== 1'b0 || drop_cnt !== 16'd5 || frame_active !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow: got level=%0d rdy=%b drop=%0d fa=%b, expected 512 0 5 0", level, din_ready, drop_cnt, frame_active);
        end
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        n_checks++;
        if (drop_cnt !== 16'd0 || level !== 10'd512) begin
            n_fail++;
            $display("FAIL drop_clear: got drop=%0d level=%0d, expected 0 512", drop_cnt, level);
        end
    endtask

    task automatic test_wrap_back_to_back();
        int early = 0;
        rst = 1'b1;
        step();
        rst  = 1'b0;
        wseq = '0;
        rseq = '0;
        gen_busy = 1'b1;
        write_words(450);
        gen_busy = 1'b0;
        for (int f = 0; f < 4; f++) run_frame();
        step();
        step();
        n_checks++;
        if (level !== 10'd34 || frames_sent !== 16'd4 || frame_active !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got level=%0d sent=%0d fa=%b, expected 34 4 0", level, frames_sent, frame_active);
        end
        gen_busy = 1'b1;
        write_words(208);
        for (int i = 0; i < 10; i++) begin
            if (frame_start !== 1'b0) early++;
            step();
        end
        n_checks++;
        if (early != 0 || level !== 10'd242) begin
            n_fail++;
            $display("FAIL busy_hold: got pulses=%0d level=%0d, expected 0 242", early, level);
        end
        gen_busy = 1'b0;
        run_frame();
        run_frame();
        n_checks++;
        if (frames_sent !== 16'd6 || level !== 10'd34 || pop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back: got sent=%0d level=%0d perr=%b, expected 6 34 0", frames_sent, level, pop_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        write_words(70);
        wait_frame_start();
        step();
        pop_words(50);
        n_checks++;
        if (frame_active !== 1'b1 || level !== 10'd54) begin
            n_fail++;
            $display("FAIL mid_frame: got fa=%b level=%0d, expected 1 54", frame_active, level);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dout !== 16'h0000 ||
            frame_start !== 1'b0 || frame_active !== 1'b0 || level !== 10'd0 ||
            drop_cnt !== 16'd0 || pop_err !== 1'b0 || frames_sent !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got rdy=%b dv=%b dout=%h fs=%b fa=%b lvl=%0d drop=%0d perr=%b sent=%0d, expected 1 0 0000 0 0 0 0 0 0",
                     din_ready, dout_valid, dout, frame_start, frame_active, level, drop_cnt, pop_err, frames_sent);
        end
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_send_frame();
        test_pop_err();
        test_full();
        test_wrap_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
